// File: rtl/e1_wb_tx_if.sv
// Register-bus port of the E1 TX control block: select/decode, strobes and
// data in both directions.
`timescale 1ns/1ps
interface e1_wb_tx_if;
  logic        bus_addr_sel;
  logic        bus_addr_lsb;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;
  logic        bus_clr;
  logic        bus_we;

  modport master (
    output bus_addr_sel, bus_addr_lsb, bus_wdata, bus_clr, bus_we,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr_sel, bus_addr_lsb, bus_wdata, bus_clr, bus_we,
    output bus_rdata
  );
endinterface

// File: rtl/e1_wb_tx.sv
// E1 transmit-side control block: control register, 4-deep "in" and "done"
// buffer-descriptor FIFOs, underflow latch and CRC E-bit source selection.
`timescale 1ns/1ps
module E1WbTxFifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem_q [4];
  logic [1:0]   wrPtr_q, wrPtr_d;
  logic [1:0]   rdPtr_q, rdPtr_d;
  logic [2:0]   count_q, count_d;
  logic         doPush, doPop;

  assign empty  = (count_q == 3'd0);
  assign full   = (count_q == 3'd4);
  assign head   = mem_q[rdPtr_q];
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;

  always_comb begin
    wrPtr_d = wrPtr_q + {1'b0, doPush};
    rdPtr_d = rdPtr_q + {1'b0, doPop};
    count_d = count_q + {2'b00, doPush} - {2'b00, doPop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= 2'd0;
      rdPtr_q <= 2'd0;
      count_q <= 3'd0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
    end else begin
      if (doPush) mem_q[wrPtr_q] <= wdata;
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end
endmodule

module e1_wb_tx #(
  parameter int MFW = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  e1_wb_tx_if.slave      bus,
  output logic [MFW-1:0] bd_mf,
  output logic [1:0]     bd_crc_e,
  output logic           bd_valid,
  input  logic           bd_done,
  input  logic           bd_miss,
  output logic [1:0]     ctrl_mode,
  output logic           ctrl_alarm,
  output logic           core_rst_n,
  input  logic [1:0]     tx_crc_e_auto,
  output logic           tx_crc_e_ack,
  output logic           irq
);
  logic           ctrlWr_q, ctrlWr_d;
  logic           bdWr_q, bdWr_d;
  logic           bdRd_q, bdRd_d;
  logic           enable_q, enable_d;
  logic [1:0]     mode_q, mode_d;
  logic           alarm_q, alarm_d;
  logic           autoE_q, autoE_d;
  logic           underflow_q, underflow_d;
  logic           coreRstN_q;
  logic           inEmpty, inFull, outEmpty, outFull;
  logic [MFW+1:0] inHead;
  logic [MFW-1:0] outHead;
  logic           unusedWdata;

  assign unusedWdata = ^bus.bus_wdata;

  // Bus strobes; full/empty are sampled here so a dropped access never
  // reaches the FIFOs one cycle later.
  always_comb begin
    ctrlWr_d = bus.bus_addr_sel & ~bus.bus_addr_lsb & bus.bus_we & ~bus.bus_clr;
    bdWr_d   = bus.bus_addr_sel & bus.bus_addr_lsb & bus.bus_we & ~bus.bus_clr & ~inFull;
    bdRd_d   = bus.bus_addr_sel & bus.bus_addr_lsb & ~bus.bus_we & ~bus.bus_clr & ~outEmpty;
  end

  always_comb begin
    enable_d    = enable_q;
    mode_d      = mode_q;
    alarm_d     = alarm_q;
    autoE_d     = autoE_q;
    underflow_d = underflow_q;
    if (ctrlWr_q) begin
      enable_d = bus.bus_wdata[0];
      mode_d   = bus.bus_wdata[2:1];
      alarm_d  = bus.bus_wdata[4];
      autoE_d  = bus.bus_wdata[5];
      if (bus.bus_wdata[12]) underflow_d = 1'b0;
    end
    // A miss in the clearing cycle must not be lost.
    if (bd_miss) underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlWr_q    <= 1'b0;
      bdWr_q      <= 1'b0;
      bdRd_q      <= 1'b0;
      enable_q    <= 1'b0;
      mode_q      <= 2'b00;
      alarm_q     <= 1'b0;
      autoE_q     <= 1'b0;
      underflow_q <= 1'b0;
      coreRstN_q  <= 1'b0;
    end else begin
      ctrlWr_q    <= ctrlWr_d;
      bdWr_q      <= bdWr_d;
      bdRd_q      <= bdRd_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      alarm_q     <= alarm_d;
      autoE_q     <= autoE_d;
      underflow_q <= underflow_d;
      coreRstN_q  <= enable_q;
    end
  end

  E1WbTxFifo #(.W(MFW + 2)) inFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bdWr_q),
    .pop   (bd_done),
    .wdata ({bus.bus_wdata[14:13], bus.bus_wdata[MFW-1:0]}),
    .head  (inHead),
    .empty (inEmpty),
    .full  (inFull)
  );

  // A completed descriptor is dropped when software has not drained the
  // done queue.
  E1WbTxFifo #(.W(MFW)) outFifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (bd_done & ~inEmpty),
    .pop   (bdRd_q),
    .wdata (inHead[MFW-1:0]),
    .head  (outHead),
    .empty (outEmpty),
    .full  (outFull)
  );

  assign bd_mf        = inHead[MFW-1:0];
  assign bd_valid     = ~inEmpty;
  assign bd_crc_e     = autoE_q ? tx_crc_e_auto : inHead[MFW+1:MFW];
  assign tx_crc_e_ack = bd_done & autoE_q;
  assign ctrl_mode    = mode_q;
  assign ctrl_alarm   = alarm_q;
  assign core_rst_n   = coreRstN_q;
  assign irq          = ~outEmpty | underflow_q;

  always_comb begin
    bus.bus_rdata = 16'h0000;
    if (bus.bus_addr_sel) begin
      if (!bus.bus_addr_lsb)
        bus.bus_rdata = {3'b000, underflow_q, outFull, outEmpty, inFull, inEmpty,
                         6'b000000, autoE_q, enable_q};
      else
        bus.bus_rdata = {~outEmpty, 2'b00, {(13 - MFW){1'b0}},
                         outHead & {MFW{~outEmpty}}};
    end
  end
endmodule

// File: tb/tb_e1_wb_tx.sv
// Directed self-checking bench for e1_wb_tx: control register, BD FIFOs,
// E-bit selection, underflow latch and asynchronous reset.
`timescale 1ns/1ps
module tb_e1_wb_tx;
  localparam int MFW = 7;

  logic           clk;
  logic           rst_n;
  logic [MFW-1:0] bd_mf;
  logic [1:0]     bd_crc_e;
  logic           bd_valid;
  logic           bd_done;
  logic           bd_miss;
  logic [1:0]     ctrl_mode;
  logic           ctrl_alarm;
  logic           core_rst_n;
  logic [1:0]     tx_crc_e_auto;
  logic           tx_crc_e_ack;
  logic           irq;
  int             assertCount;
  int             failCount;

  e1_wb_tx_if bus();

  e1_wb_tx #(.MFW(MFW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .bd_mf         (bd_mf),
    .bd_crc_e      (bd_crc_e),
    .bd_valid      (bd_valid),
    .bd_done       (bd_done),
    .bd_miss       (bd_miss),
    .ctrl_mode     (ctrl_mode),
    .ctrl_alarm    (ctrl_alarm),
    .core_rst_n    (core_rst_n),
    .tx_crc_e_auto (tx_crc_e_auto),
    .tx_crc_e_ack  (tx_crc_e_ack),
    .irq           (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busIdle();
    bus.bus_addr_sel = 1'b0;
    bus.bus_addr_lsb = 1'b0;
    bus.bus_we       = 1'b0;
    bus.bus_clr      = 1'b1;
  endtask

  task automatic busWrite(input logic lsb, input logic [15:0] data);
    bus.bus_addr_sel = 1'b1;
    bus.bus_addr_lsb = lsb;
    bus.bus_we       = 1'b1;
    bus.bus_clr      = 1'b0;
    bus.bus_wdata    = data;
    step();
    busIdle();
    step();
  endtask

  task automatic busRead(output logic [15:0] data);
    bus.bus_addr_sel = 1'b1;
    bus.bus_addr_lsb = 1'b1;
    bus.bus_we       = 1'b0;
    bus.bus_clr      = 1'b0;
    #1;
    data = bus.bus_rdata;
    step();
    busIdle();
    step();
  endtask

  task automatic statusRead(output logic [15:0] data);
    bus.bus_addr_sel = 1'b1;
    bus.bus_addr_lsb = 1'b0;
    bus.bus_we       = 1'b0;
    bus.bus_clr      = 1'b0;
    #1;
    data = bus.bus_rdata;
    busIdle();
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] st;
    rst_n = 1'b0;
    step();
    step();
    statusRead(st);
    assertCount++; if (st !== 16'h0500) begin failCount++; $display("[TB] FAIL reset_status: got %h expected %h", st, 16'h0500); end
    assertCount++; if (core_rst_n !== 1'b0) begin failCount++; $display("[TB] FAIL reset_core_rst_n: got %b expected 0", core_rst_n); end
    assertCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL reset_irq: got %b expected 0", irq); end
    assertCount++; if ({bd_valid, tx_crc_e_ack, ctrl_mode, ctrl_alarm} !== 5'b00000) begin failCount++; $display("[TB] FAIL reset_outputs: got %b expected 00000", {bd_valid, tx_crc_e_ack, ctrl_mode, ctrl_alarm}); end
    rst_n = 1'b1;
    step();
    step();
    statusRead(st);
    assertCount++; if (st !== 16'h0500) begin failCount++; $display("[TB] FAIL post_reset_status: got %h expected %h", st, 16'h0500); end
    assertCount++; if (bus.bus_rdata !== 16'h0000) begin failCount++; $display("[TB] FAIL unselected_rdata: got %h expected 0000", bus.bus_rdata); end
  endtask

  task automatic test_control();
    logic [15:0] st;
    bus.bus_addr_sel = 1'b1;
    bus.bus_addr_lsb = 1'b0;
    bus.bus_we       = 1'b1;
    bus.bus_clr      = 1'b0;
    bus.bus_wdata    = 16'h0023;
    step();
    busIdle();
    assertCount++; if (ctrl_mode !== 2'b00) begin failCount++; $display("[TB] FAIL ctrl_early: got %b expected 00", ctrl_mode); end
    step();
    assertCount++; if (ctrl_mode !== 2'b01) begin failCount++; $display("[TB] FAIL ctrl_mode: got %b expected 01", ctrl_mode); end
    assertCount++; if (core_rst_n !== 1'b0) begin failCount++; $display("[TB] FAIL core_rst_early: got %b expected 0", core_rst_n); end
    step();
    assertCount++; if (core_rst_n !== 1'b1) begin failCount++; $display("[TB] FAIL core_rst_rise: got %b expected 1", core_rst_n); end
    statusRead(st);
    assertCount++; if (st !== 16'h0503) begin failCount++; $display("[TB] FAIL ctrl_status: got %h expected %h", st, 16'h0503); end
    busWrite(1'b0, 16'h0011);
    assertCount++; if ({ctrl_alarm, ctrl_mode} !== 3'b100) begin failCount++; $display("[TB] FAIL ctrl_alarm: got %b expected 100", {ctrl_alarm, ctrl_mode}); end
  endtask

  task automatic test_bd_single();
    logic [15:0] rd;
    bus.bus_addr_sel = 1'b1;
    bus.bus_addr_lsb = 1'b1;
    bus.bus_we       = 1'b1;
    bus.bus_clr      = 1'b0;
    bus.bus_wdata    = 16'h6005;
    step();
    busIdle();
    assertCount++; if (bd_valid !== 1'b0) begin failCount++; $display("[TB] FAIL bd_valid_early: got %b expected 0", bd_valid); end
    step();
    assertCount++; if ({bd_valid, bd_crc_e, bd_mf} !== {1'b1, 2'b11, 7'd5}) begin failCount++; $display("[TB] FAIL bd_head: got %b expected %b", {bd_valid, bd_crc_e, bd_mf}, {1'b1, 2'b11, 7'd5}); end
    bd_done = 1'b1;
    #1;
    assertCount++; if (tx_crc_e_ack !== 1'b0) begin failCount++; $display("[TB] FAIL ack_manual: got %b expected 0", tx_crc_e_ack); end
    step();
    bd_done = 1'b0;
    assertCount++; if ({bd_valid, irq} !== 2'b01) begin failCount++; $display("[TB] FAIL done_irq: got %b expected 01", {bd_valid, irq}); end
    busRead(rd);
    assertCount++; if (rd !== 16'h8005) begin failCount++; $display("[TB] FAIL bd_read: got %h expected %h", rd, 16'h8005); end
    assertCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL irq_after_read: got %b expected 0", irq); end
    bd_done = 1'b1;
    step();
    bd_done = 1'b0;
    assertCount++; if (irq !== 1'b0) begin failCount++; $display("[TB] FAIL done_when_empty: got irq %b expected 0", irq); end
  endtask

  task automatic test_fill();
    logic [15:0] st;
    logic [15:0] rd;
    for (int i = 1; i <= 5; i++) busWrite(1'b1, 16'(i));
    statusRead(st);
    assertCount++; if (st !== 16'h0601) begin failCount++; $display("[TB] FAIL fill_status: got %h expected %h", st, 16'h0601); end
    for (int i = 1; i <= 4; i++) begin
      assertCount++; if (bd_mf !== 7'(i)) begin failCount++; $display("[TB] FAIL fill_order: got %0d expected %0d", bd_mf, i); end
      bd_done = 1'b1;
      step();
      bd_done = 1'b0;
      step();
    end
    statusRead(st);
    assertCount++; if (st !== 16'h0901) begin failCount++; $display("[TB] FAIL drained_status: got %h expected %h", st, 16'h0901); end
    for (int i = 1; i <= 4; i++) begin
      busRead(rd);
      assertCount++; if (rd !== (16'h8000 | 16'(i))) begin failCount++; $display("[TB] FAIL done_read: got %h expected %h", rd, 16'h8000 | 16'(i)); end
    end
    busRead(rd);
    assertCount++; if (rd !== 16'h0000) begin failCount++; $display("[TB] FAIL empty_read: got %h expected 0000", rd); end
  endtask

  task automatic test_auto_e();
    logic [15:0] rd;
    busWrite(1'b0, 16'h0021);
    tx_crc_e_auto = 2'b10;
    busWrite(1'b1, 16'h6009);
    assertCount++; if ({bd_crc_e, bd_mf} !== {2'b10, 7'd9}) begin failCount++; $display("[TB] FAIL auto_e_bits: got %b expected %b", {bd_crc_e, bd_mf}, {2'b10, 7'd9}); end
    tx_crc_e_auto = 2'b01;
    #1;
    assertCount++; if (bd_crc_e !== 2'b01) begin failCount++; $display("[TB] FAIL auto_e_follow: got %b expected 01", bd_crc_e); end
    bd_done = 1'b1;
    #1;
    assertCount++; if (tx_crc_e_ack !== 1'b1) begin failCount++; $display("[TB] FAIL ack_pulse: got %b expected 1", tx_crc_e_ack); end
    step();
    bd_done = 1'b0;
    #1;
    assertCount++; if (tx_crc_e_ack !== 1'b0) begin failCount++; $display("[TB] FAIL ack_end: got %b expected 0", tx_crc_e_ack); end
    busRead(rd);
    assertCount++; if (rd !== 16'h8009) begin failCount++; $display("[TB] FAIL auto_read: got %h expected %h", rd, 16'h8009); end
  endtask

  task automatic test_underflow();
    logic [15:0] st;
    bd_miss = 1'b1;
    step();
    bd_miss = 1'b0;
    statusRead(st);
    assertCount++; if ({st, irq} !== {16'h1503, 1'b1}) begin failCount++; $display("[TB] FAIL underflow_set: got %h/%b expected 1503/1", st, irq); end
    busWrite(1'b0, 16'h1001);
    statusRead(st);
    assertCount++; if ({st, irq} !== {16'h0501, 1'b0}) begin failCount++; $display("[TB] FAIL underflow_clear: got %h/%b expected 0501/0", st, irq); end
    bus.bus_addr_sel = 1'b1;
    bus.bus_addr_lsb = 1'b0;
    bus.bus_we       = 1'b1;
    bus.bus_clr      = 1'b0;
    bus.bus_wdata    = 16'h1001;
    step();
    busIdle();
    bd_miss = 1'b1;
    step();
    bd_miss = 1'b0;
    statusRead(st);
    assertCount++; if (st !== 16'h1501) begin failCount++; $display("[TB] FAIL miss_wins: got %h expected %h", st, 16'h1501); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] st;
    busWrite(1'b1, 16'h0003);
    assertCount++; if (bd_valid !== 1'b1) begin failCount++; $display("[TB] FAIL pre_reset_valid: got %b expected 1", bd_valid); end
    bus.bus_addr_sel = 1'b1;
    bus.bus_addr_lsb = 1'b0;
    bus.bus_we       = 1'b1;
    bus.bus_clr      = 1'b0;
    bus.bus_wdata    = 16'h0005;
    step();
    busIdle();
    #2;
    rst_n = 1'b0;
    #1;
    assertCount++; if ({bd_valid, core_rst_n, irq} !== 3'b000) begin failCount++; $display("[TB] FAIL async_reset: got %b expected 000", {bd_valid, core_rst_n, irq}); end
    statusRead(st);
    assertCount++; if (st !== 16'h0500) begin failCount++; $display("[TB] FAIL async_reset_status: got %h expected %h", st, 16'h0500); end
    rst_n = 1'b1;
    step();
    step();
    step();
    assertCount++; if ({ctrl_mode, core_rst_n} !== 3'b000) begin failCount++; $display("[TB] FAIL strobe_lost: got %b expected 000", {ctrl_mode, core_rst_n}); end
  endtask

  initial begin
    assertCount   = 0;
    failCount     = 0;
    rst_n         = 1'b0;
    bd_done       = 1'b0;
    bd_miss       = 1'b0;
    tx_crc_e_auto = 2'b00;
    bus.bus_wdata = 16'h0000;
    busIdle();
    test_reset();
    test_control();
    test_bd_single();
    test_fill();
    test_auto_e();
    test_underflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
